// File: rtl/bus_pkg.sv
// Shared FSM encoding and defaults for the round-robin bus controller.
// Bus-wide constants live here so the top and the bench agree on them.
package bus_pkg;

  typedef enum logic [1:0] {
    st_idle    = 2'd0,
    st_pop     = 2'd1,
    st_deliver = 2'd2
  } state_t;

  localparam int          ID_BITS_DEF = 8;
  localparam logic [31:0] BCAST_DEF   = 32'hFFFF_FFFF;
  localparam logic [15:0] DROP_MAX    = 16'hFFFF;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest-index requester at or after last+1 (mod N).
// Zero latency; o_grant holds i_last when nothing is requesting.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic          o_any,
  output logic [IW-1:0] o_grant
);

  always_comb begin : p_sel
    int            w_idx;
    logic [IW-1:0] w_sel;
    o_any   = |i_req;
    o_grant = i_last;
    w_idx   = 0;
    w_sel   = '0;
    // Walk from farthest to nearest so the nearest requester wins last.
    for (int k = N; k >= 1; k--) begin
      w_idx = int'(i_last) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      w_sel = IW'(w_idx);
      if (i_req[w_sel]) o_grant = w_sel;
    end
  end

endmodule

// File: rtl/bus_rr_ctrl.sv
// Round-robin shared bus: IDLE -> POP -> DELIVER, pop one cycle after request, push one after that.
// No backpressure (1 packet / 3 cycles); define BUS_RR_BCAST_EN to deliver dest==BCAST to all but the source.
module bus_rr_ctrl
  import bus_pkg::*;
#(
  parameter int                 DEVICES = 4,
  parameter int                 WIDTH   = 16,
  parameter int                 ID_BITS = ID_BITS_DEF,
  parameter logic [ID_BITS-1:0] BCAST   = BCAST_DEF[ID_BITS-1:0]
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DEVICES-1:0]                pndng,
  input  logic [DEVICES-1:0][WIDTH-1:0]     D_pop,
  output logic [DEVICES-1:0]                pop,
  output logic [DEVICES-1:0]                push,
  output logic [DEVICES-1:0][WIDTH-1:0]     D_push,
  output logic                              busy,
  output logic [$clog2(DEVICES)-1:0]        grant_id,
  output logic [15:0]                       drop_cnt
);

  localparam int IW = $clog2(DEVICES);

  state_t             r_state;
  state_t             w_next;
  logic [IW-1:0]      r_grant;
  logic [WIDTH-1:0]   r_pkt;
  logic [15:0]        r_drop;

  logic               w_any;
  logic [IW-1:0]      w_rr_grant;
  logic [ID_BITS-1:0] w_dest;
  logic               w_is_bcast;
  logic               w_uni_ok;
  logic               w_drop;

  rr_arbiter #(
    .N  (DEVICES),
    .IW (IW)
  ) u_arb (
    .i_req   (pndng),
    .i_last  (r_grant),
    .o_any   (w_any),
    .o_grant (w_rr_grant)
  );

  assign w_dest     = r_pkt[WIDTH-1 -: ID_BITS];
  assign w_is_bcast = (w_dest == BCAST);
  assign w_uni_ok   = (int'(w_dest) < DEVICES) && (int'(w_dest) != int'(r_grant)) && !w_is_bcast;

`ifdef BUS_RR_BCAST_EN
  assign w_drop = !(w_uni_ok || w_is_bcast);
`else
  assign w_drop = !w_uni_ok;
`endif

  always_comb begin
    w_next = r_state;
    pop    = '0;
    push   = '0;
    unique case (r_state)
      st_idle:    if (w_any) w_next = st_pop;
      st_pop:     w_next = st_deliver;
      st_deliver: w_next = st_idle;
      default:    w_next = st_idle;
    endcase
    for (int i = 0; i < DEVICES; i++) begin
      if (r_state == st_pop && int'(r_grant) == i) pop[i] = 1'b1;
      if (r_state == st_deliver) begin
        if (w_uni_ok && int'(w_dest) == i) push[i] = 1'b1;
`ifdef BUS_RR_BCAST_EN
        if (w_is_bcast && int'(r_grant) != i) push[i] = 1'b1;
`endif
      end
    end
  end

  // Packet is latched on the edge that leaves POP, i.e. the cycle pop is asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= st_idle;
      r_grant <= IW'(DEVICES - 1);
      r_pkt   <= '0;
      r_drop  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == st_idle && w_any) r_grant <= w_rr_grant;
      if (r_state == st_pop) r_pkt <= D_pop[r_grant];
      if (r_state == st_deliver && w_drop && r_drop != DROP_MAX) r_drop <= r_drop + 16'd1;
    end
  end

  assign busy     = (r_state != st_idle);
  assign grant_id = r_grant;
  assign drop_cnt = r_drop;
  assign D_push   = {DEVICES{r_pkt}};

endmodule

// File: tb/tb_bus_rr_ctrl.sv
// Scoreboard bench for bus_rr_ctrl: device queues feed the bus, a queue-based
// round-robin model predicts pop/push events, a negedge monitor checks them.
module tb_bus_rr_ctrl;

  localparam int N = 4;
  localparam int W = 16;
`ifdef BUS_RR_BCAST_EN
  localparam bit BC_EN = 1'b1;
`else
  localparam bit BC_EN = 1'b0;
`endif
  localparam int K_POP  = 0;
  localparam int K_PUSH = 1;
  localparam int K_STAT = 2;

  typedef struct {
    int          kind;
    logic [3:0]  mask;
    logic [15:0] dat;
    bit          first;
    logic [15:0] drop;
    logic        busy;
    logic [1:0]  grant;
  } item_t;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [N-1:0]        pndng;
  logic [N-1:0]        pop;
  logic [N-1:0]        push;
  logic [N-1:0][W-1:0] D_pop;
  logic [N-1:0][W-1:0] D_push;
  logic                busy;
  logic [1:0]          grant_id;
  logic [15:0]         drop_cnt;

  bus_rr_ctrl #(.DEVICES(N), .WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .pndng    (pndng),
    .D_pop    (D_pop),
    .pop      (pop),
    .push     (push),
    .D_push   (D_push),
    .busy     (busy),
    .grant_id (grant_id),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  item_t       exp_q[$];
  item_t       it;
  int          rd = 0;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_pop = -10;
  int          pop_count[N];
  int          applied[N];
  logic [15:0] dq[N][$];
  logic [N-1:0] hide;
  int          mptr;
  int          mdrop;

  // Monitor: consumes expected events in order whenever the DUT shows activity.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) if (pop[i]) pop_count[i]++;
      if (!reset) begin
        if ((pop | push) != 0) begin
          if (rd >= exp_q.size()) begin
            total++; bad++;
            $display("FAIL unexpected_event got pop=%b push=%b want none (cyc %0d)", pop, push, cyc);
          end else begin
            it = exp_q[rd];
            rd++;
            if (it.kind == K_POP) begin
              total++;
              if (pop !== it.mask || push !== 4'b0000) begin
                bad++;
                $display("FAIL pop_lane got pop=%b push=%b want pop=%b push=0000", pop, push, it.mask);
              end
              if (!it.first) begin
                total++;
                if (cyc - last_pop != 3) begin
                  bad++;
                  $display("FAIL pop_spacing got %0d want 3", cyc - last_pop);
                end
              end
              last_pop = cyc;
            end else if (it.kind == K_PUSH) begin
              total++;
              if (push !== it.mask || pop !== 4'b0000) begin
                bad++;
                $display("FAIL push_mask got push=%b pop=%b want push=%b pop=0000", push, pop, it.mask);
              end
              total++;
              if (D_push !== {N{it.dat}}) begin
                bad++;
                $display("FAIL push_data got %h want lanes of %h", D_push, it.dat);
              end
              total++;
              if (cyc - last_pop != 1) begin
                bad++;
                $display("FAIL push_latency got %0d want 1", cyc - last_pop);
              end
            end else begin
              total++; bad++;
              $display("FAIL event_when_idle got pop=%b push=%b want none", pop, push);
            end
          end
        end else if (rd < exp_q.size() && exp_q[rd].kind == K_STAT) begin
          it = exp_q[rd];
          rd++;
          total++;
          if (busy !== it.busy) begin
            bad++; $display("FAIL stat_busy got %b want %b", busy, it.busy);
          end
          total++;
          if (drop_cnt !== it.drop) begin
            bad++; $display("FAIL stat_drop_cnt got %0d want %0d", drop_cnt, it.drop);
          end
          total++;
          if (grant_id !== it.grant) begin
            bad++; $display("FAIL stat_grant_id got %0d want %0d", grant_id, it.grant);
          end
        end
      end
    end
  end

  function automatic void add(input int kind, input logic [3:0] mask, input logic [15:0] dat, input bit first);
    item_t e;
    e.kind  = kind;
    e.mask  = mask;
    e.dat   = dat;
    e.first = first;
    e.drop  = mdrop[15:0];
    e.busy  = 1'b0;
    e.grant = mptr[1:0];
    exp_q.push_back(e);
  endfunction

  function automatic void drive();
    for (int i = 0; i < N; i++) begin
      pndng[i] = (dq[i].size() != 0) && !hide[i];
      D_pop[i] = (dq[i].size() != 0) ? dq[i][0] : 16'h0000;
    end
  endfunction

  function automatic void load(input int d, input logic [15:0] pkt);
    dq[d].push_back(pkt);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      while (applied[i] < pop_count[i]) begin
        if (dq[i].size() != 0) void'(dq[i].pop_front());
        applied[i]++;
      end
    end
    drive();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (rd != exp_q.size()) begin
      step();
      n++;
      if (n > 600) begin
        $display("FAIL drain_timeout got %0d events seen want %0d", rd, exp_q.size());
        $fatal(1, "bus stalled");
      end
    end
  endtask

  // Reference: with all packets queued up front, service is a pure rotation over non-empty queues.
  task automatic model_phase();
    logic [15:0] mq[N][$];
    logic [15:0] pkt;
    logic [7:0]  dest;
    logic [3:0]  m;
    bit          first;
    int          found;
    for (int i = 0; i < N; i++) mq[i] = dq[i];
    first = 1'b1;
    found = 0;
    while (found >= 0) begin
      found = -1;
      for (int k = 1; k <= N; k++)
        if (found < 0 && mq[(mptr + k) % N].size() != 0) found = (mptr + k) % N;
      if (found >= 0) begin
        mptr = found;
        pkt  = mq[found].pop_front();
        add(K_POP, 4'b0001 << found, 16'h0000, first);
        first = 1'b0;
        dest = pkt[15:8];
        if (BC_EN && dest == 8'hFF) m = 4'hF & ~(4'b0001 << found);
        else if (dest < N && dest != found) m = 4'b0001 << dest;
        else m = 4'b0000;
        if (m != 0) add(K_PUSH, m, pkt, 1'b0);
        else if (mdrop < 65535) mdrop++;
      end
    end
  endtask

  task automatic check_stat();
    add(K_STAT, 4'b0000, 16'h0000, 1'b0);
    wait_drain();
  endtask

  task automatic run_phase(input logic [N-1:0] hide_after);
    model_phase();
    drive();
    if (hide_after != 0) begin
      step();
      hide = hide_after;
      drive();
    end
    wait_drain();
    hide = '0;
    drive();
    repeat (3) step();
    check_stat();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    mptr  = N - 1;
    mdrop = 0;
  endtask

  initial begin
    int n;
    logic [7:0] dest;
    hide  = '0;
    mptr  = N - 1;
    mdrop = 0;
    drive();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_stat();

    // Single packet, device 1 to device 2.
    load(1, 16'h02AB);
    run_phase('0);

    // All devices continuously pending from reset: rotation 0,1,2,3,0,...
    step();
    pulse_reset();
    check_stat();
    for (int d = 0; d < N; d++) begin
      load(d, {8'((d + 1) % N), 8'(d)});
      load(d, {8'((d + 2) % N), 8'(8'h10 + d)});
    end
    run_phase('0);

    // Self-addressed and out-of-range destinations are dropped.
    load(0, 16'h0011);
    load(0, 16'h0711);
    run_phase('0);

    // Broadcast address from device 2.
    load(2, 16'hFF55);
    run_phase('0);

    // Request withdrawn while in POP is still served.
    load(3, 16'h0133);
    run_phase(4'b1000);

    for (int p = 0; p < 12; p++) begin
      for (int d = 0; d < N; d++) begin
        repeat ($urandom_range(0, 3)) begin
          dest = ($urandom_range(0, 6) == 6) ? 8'hFF : 8'($urandom_range(0, 5));
          load(d, {dest, 8'($urandom)});
        end
      end
      run_phase('0);
    end

    // Reset landing in the POP cycle aborts the transfer.
    load(1, 16'h0042);
    drive();
    n = 0;
    while (pop == 0 && n < 20) begin
      step();
      n++;
    end
    if (pop == 0) begin
      $display("FAIL pop_wait_timeout got pop=%b want one-hot", pop);
      $fatal(1, "no pop");
    end
    hide = '1;
    drive();
    pulse_reset();
    check_stat();
    hide = '0;
    load(0, 16'h0155);
    load(2, 16'h0366);
    run_phase('0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
